mux_scan_sequencer: RTL and testbench

//  Upstream controller for the 4:1 WIDTH-bit channel mux. Drives the mux select, waits a

---
 rtl/mux_scan_sequencer.sv | 125 ++++++++++++
 tb/tb_mux_scan_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sequencer.sv
// Round-robin scan controller for a 4:1 channel mux with valid/ready sample output.
// Optional MUX_SCAN_DROP_EN: never stall, overwrite unaccepted samples, flag overrun.
module mux_scan_sequencer #(
  parameter int WIDTH = 4,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [3:0]       ch_mask,
  output logic [1:0]       sel,
  input  logic [WIDTH-1:0] mux_out,
  output logic [WIDTH-1:0] smp_data,
  output logic [1:0]       smp_ch,
  output logic             smp_valid,
  input  logic             smp_ready,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    WAIT
  } state_t;

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       stop_pend;
  logic       hs;
  logic [1:0] first;
  logic [1:0] nxt;

  function automatic logic [1:0] first_ch(
    input logic [3:0] m
  );
    first_ch = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) first_ch = 2'(i);
    end
  endfunction

  // Search from offset 4 down to 1 so the nearest index above cur wins;
  // offset 4 wraps back to cur itself when it is the only enabled channel.
  function automatic logic [1:0] next_ch(
    input logic [1:0] cur,
    input logic [3:0] m
  );
    logic [1:0] n;
    next_ch = cur;
    for (int i = 4; i >= 1; i--) begin
      n = cur + 2'(i);
      if (m[n]) next_ch = n;
    end
  endfunction

  assign hs    = smp_valid && smp_ready;
  assign first = first_ch(ch_mask);
  assign nxt   = next_ch(sel, ch_mask);
  assign busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      sel       <= 2'd0;
      smp_data  <= '0;
      smp_ch    <= 2'd0;
      smp_valid <= 1'b0;
      stop_pend <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (hs) smp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !stop && ch_mask != 4'd0) begin
            state <= SETTLE;
            sel   <= first;
            cnt   <= 8'd0;
`ifdef MUX_SCAN_DROP_EN
            overrun <= 1'b0;
`endif
          end
        end
        SETTLE: begin
          if (stop) begin
            state <= IDLE;
          end else if (cnt == LAST) begin
            smp_data  <= mux_out;
            smp_ch    <= sel;
            smp_valid <= 1'b1;
`ifdef MUX_SCAN_DROP_EN
            if (smp_valid && !smp_ready) overrun <= 1'b1;
            cnt <= 8'd0;
            if (ch_mask == 4'd0) state <= IDLE;
            else sel <= nxt;
`else
            state <= WAIT;
`endif
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WAIT: begin
          if (stop) stop_pend <= 1'b1;
          if (hs) begin
            stop_pend <= 1'b0;
            if (stop || stop_pend || ch_mask == 4'd0) begin
              state <= IDLE;
            end else begin
              sel   <= nxt;
              cnt   <= 8'd0;
              state <= SETTLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer (WIDTH=4, DWELL=4).
// Mux model returns sel+1, i.e. channels a..d carry 1..4.
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic [3:0] ch_mask;
  logic [1:0] sel;
  logic [3:0] mux_out;
  logic [3:0] smp_data;
  logic [1:0] smp_ch;
  logic       smp_valid;
  logic       smp_ready;
  logic       busy;
  logic       overrun;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign mux_out = {2'b00, sel} + 4'd1;

  mux_scan_sequencer #(
    .WIDTH(4),
    .DWELL(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .ch_mask  (ch_mask),
    .sel      (sel),
    .mux_out  (mux_out),
    .smp_data (smp_data),
    .smp_ch   (smp_ch),
    .smp_valid(smp_valid),
    .smp_ready(smp_ready),
    .busy     (busy),
    .overrun  (overrun)
  );

  typedef struct {
    logic       start;
    logic       ready;
    logic [3:0] mask;
    logic       ev;
    logic [1:0] esel;
    logic [1:0] ech;
    logic [3:0] edata;
    logic       ebusy;
  } vec_t;

  vec_t tv[25];

  task automatic chk(input string nm, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int e2[5];
    rst       = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    ch_mask   = 4'b0000;
    smp_ready = 1'b0;
    tick();
    chk("rst_sel", sel, 0);
    chk("rst_data", smp_data, 0);
    chk("rst_ch", smp_ch, 0);
    chk("rst_valid", smp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    rst = 1'b0;

`ifndef MUX_SCAN_DROP_EN
    // test 1: full mask, ready tied high, period 5
    for (int k = 0; k < 25; k++) begin
      tv[k].start = (k == 0);
      tv[k].ready = 1'b1;
      tv[k].mask  = 4'b1111;
      tv[k].ev    = (k % 5 == 4);
      tv[k].esel  = 2'((k / 5) % 4);
      tv[k].ech   = 2'((k / 5) % 4);
      tv[k].edata = 4'((k / 5) % 4 + 1);
      tv[k].ebusy = 1'b1;
    end
    for (int k = 0; k < 25; k++) begin
      start     = tv[k].start;
      smp_ready = tv[k].ready;
      ch_mask   = tv[k].mask;
      tick();
      start = 1'b0;
      chk($sformatf("t1_valid[%0d]", k), smp_valid, tv[k].ev);
      chk($sformatf("t1_sel[%0d]", k), sel, tv[k].esel);
      chk($sformatf("t1_busy[%0d]", k), busy, tv[k].ebusy);
      if (tv[k].ev) begin
        chk($sformatf("t1_ch[%0d]", k), smp_ch, tv[k].ech);
        chk($sformatf("t1_data[%0d]", k), smp_data, tv[k].edata);
      end
    end

    // test 2: sparse mask, then mask change while settling on ch3
    do_reset();
    e2 = '{1, 3, 1, 3, 2};
    ch_mask   = 4'b1010;
    smp_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_first_sel", sel, 1);
    for (int k = 1; k < 25; k++) begin
      if (k == 16) ch_mask = 4'b0100;
      tick();
      if (k % 5 == 4) begin
        chk($sformatf("t2_valid[%0d]", k), smp_valid, 1);
        chk($sformatf("t2_ch[%0d]", k), smp_ch, e2[k/5]);
        chk($sformatf("t2_data[%0d]", k), smp_data, e2[k/5] + 1);
      end
    end

    // test 3: back-pressure holds the sample and sel
    do_reset();
    ch_mask   = 4'b1111;
    smp_ready = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("t3_valid", smp_valid, 1);
    chk("t3_data", smp_data, 1);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("t3_hold_v[%0d]", k), smp_valid, 1);
      chk($sformatf("t3_hold_d[%0d]", k), smp_data, 1);
      chk($sformatf("t3_hold_s[%0d]", k), sel, 0);
    end
    smp_ready = 1'b1;
    tick();
    chk("t3_rel_valid", smp_valid, 0);
    chk("t3_rel_sel", sel, 1);

    // test 4a: stop at cnt=2 aborts without a sample
    do_reset();
    ch_mask   = 4'b1111;
    smp_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t4a_busy", busy, 0);
    chk("t4a_valid", smp_valid, 0);
    repeat (6) tick();
    chk("t4a_valid_late", smp_valid, 0);
    chk("t4a_busy_late", busy, 0);

    // test 4b: stop during WAIT delivers the sample then idles
    do_reset();
    ch_mask   = 4'b1111;
    smp_ready = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("t4b_valid", smp_valid, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t4b_busy", busy, 1);
    chk("t4b_valid_held", smp_valid, 1);
    repeat (3) tick();
    chk("t4b_busy_wait", busy, 1);
    smp_ready = 1'b1;
    tick();
    chk("t4b_busy_hs", busy, 0);
    chk("t4b_valid_hs", smp_valid, 0);
    chk("t4b_sel_hs", sel, 0);
    tick();
    chk("t4b_busy_after", busy, 0);
`else
    // drop mode: second capture overwrites and flags overrun
    do_reset();
    ch_mask   = 4'b1111;
    smp_ready = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("d_valid1", smp_valid, 1);
    chk("d_data1", smp_data, 1);
    chk("d_ovr1", overrun, 0);
    repeat (4) tick();
    chk("d_data2", smp_data, 2);
    chk("d_ch2", smp_ch, 1);
    chk("d_ovr2", overrun, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("d_busy_stop", busy, 0);
    chk("d_valid_idle", smp_valid, 1);
    chk("d_ovr_sticky", overrun, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("d_ovr_clr", overrun, 0);
`endif

    // test 5: reset mid-transfer, then ignored starts
    do_reset();
    ch_mask   = 4'b0100;
    smp_ready = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("t5_pre_valid", smp_valid, 1);
    chk("t5_pre_data", smp_data, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_sel", sel, 0);
    chk("t5_data", smp_data, 0);
    chk("t5_ch", smp_ch, 0);
    chk("t5_valid", smp_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ovr", overrun, 0);
    ch_mask = 4'b0000;
    start   = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_mask0_busy", busy, 0);
    ch_mask = 4'b1111;
    start   = 1'b1;
    stop    = 1'b1;
    tick();
    stop = 1'b0;
    chk("t5_startstop_busy", busy, 0);
    tick();
    start = 1'b0;
    chk("t5_start_busy", busy, 1);
    chk("t5_start_sel", sel, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
